pipe_skid_stage: RTL and testbench

Parametrised, elastic pipeline-stage register for the 16-bit WISC pipeline. It replaces the fixed-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block. Each instance carries an instruction word, a data payload and a control vector across one stage boundary. It adds a valid/ready handshake with a 2-entry skid buffer, so stalls never need a combinational ready path, and it adds a flush that turns in-flight entries into bubbles.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_skid_stage_if.sv | 30 +++
 rtl/skid_entry.sv | 19 +
 rtl/pipe_skid_stage.sv | 129 ++++++++++++
 tb/tb_pipe_skid_stage.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage register and its users.
package pipe_pkg;

    // Occupancy of a stage: the encoding is the number of held entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Instruction word presented whenever no valid entry is at the output.
    localparam logic [15:0] NOP_INSTR = 16'b00001_00000000000;

    // Control bits cleared on a bubble. The hazard unit and the stage
    // instances use these constants so that they agree on bit positions.
    localparam logic [11:0] IDEX_KILL_MASK  = 12'h0F0;
    localparam logic [11:0] EXMEM_KILL_MASK = 12'h030;

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Valid/ready handshake and payload bundle for one pipeline-stage boundary.
interface pipe_skid_stage_if #(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned DATA_W  = 112,
    parameter int unsigned CTRL_W  = 12
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [DATA_W-1:0]  in_data;
    logic [CTRL_W-1:0]  in_ctrl;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [DATA_W-1:0]  out_data;
    logic [CTRL_W-1:0]  out_ctrl;
    logic [1:0]         occupancy;

    // The side that feeds entries in and consumes them at the output.
    modport master (
        output in_valid, in_instr, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_instr, out_data, out_ctrl, occupancy
    );

    // The stage register itself.
    modport slave (
        input  in_valid, in_instr, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_instr, out_data, out_ctrl, occupancy
    );
endinterface

// File: rtl/skid_entry.sv
// One storage slot of the stage: a plain word register with a load enable.
// Not reset: validity is tracked by the owning FSM.
module skid_entry #(
    parameter int unsigned W = 140
) (
    input  logic         clk,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture the word only when the owner asks for it.
    always_ff @(posedge clk) begin
        if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline-stage register: two-entry skid buffer with flush-to-bubble.
//
//   state | meaning
//   ------+--------------------------------------------------
//   EMPTY | nothing held; outputs show a bubble
//   HALF  | main entry held and driving the outputs
//   FULL  | main and skid held; in_ready low until a pop
module pipe_skid_stage #(
    parameter int unsigned       INSTR_W   = 16,
    parameter int unsigned       DATA_W    = 112,
    parameter int unsigned       CTRL_W    = 12,
    parameter logic [INSTR_W-1:0] NOP_INSTR = pipe_pkg::NOP_INSTR,
    parameter logic [CTRL_W-1:0] KILL_MASK = '1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    pipe_skid_stage_if.slave      bus
);
    import pipe_pkg::*;

    localparam int unsigned W = INSTR_W + DATA_W + CTRL_W;

    state_t         state_q, state_d;
    logic           push, pop, in_ready_w, out_valid_w;
    logic           load_main, load_skid, main_from_skid;
    logic           ctrl_live_q;
    logic [W-1:0]   in_word, main_d, main_q, skid_q;
    logic [CTRL_W-1:0] main_ctrl;

    assign in_ready_w  = (state_q != FULL);
    assign out_valid_w = (state_q != EMPTY);
    assign push        = bus.in_valid && in_ready_w;
    assign pop         = out_valid_w && bus.out_ready;
    assign in_word     = {bus.in_instr, bus.in_data, bus.in_ctrl};
    assign main_d      = main_from_skid ? skid_q : in_word;

    // State register; reset wins over everything else.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and slot load strobes; flush discards everything, including
    // an entry offered in the same cycle.
    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d   = HALF;
                        load_main = 1'b1;
                    end
                end
                HALF: begin
                    if (push && !pop) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (push && pop) begin
                        load_main = 1'b1;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d        = HALF;
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Remembers whether main has ever been loaded since reset, so a bubble
    // right after reset shows a zero control vector rather than stale data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_live_q <= 1'b0;
        end else if (load_main) begin
            ctrl_live_q <= 1'b1;
        end
    end

    skid_entry #(.W(W)) u_main (
        .clk  (clk),
        .load (load_main),
        .d    (main_d),
        .q    (main_q)
    );

    skid_entry #(.W(W)) u_skid (
        .clk  (clk),
        .load (load_skid),
        .d    (in_word),
        .q    (skid_q)
    );

    assign main_ctrl = main_q[CTRL_W-1:0];

    // Outputs come from registered state only; a bubble keeps the unmasked
    // control bits of the last held entry.
    always_comb begin
        bus.in_ready  = in_ready_w;
        bus.out_valid = out_valid_w;
        bus.occupancy = state_q;
        bus.out_data  = main_q[CTRL_W +: DATA_W];
        bus.out_instr = out_valid_w ? main_q[CTRL_W+DATA_W +: INSTR_W] : NOP_INSTR;
        if (out_valid_w) begin
            bus.out_ctrl = main_ctrl;
        end else if (ctrl_live_q) begin
            bus.out_ctrl = main_ctrl & ~KILL_MASK;
        end else begin
            bus.out_ctrl = '0;
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed plus random bench for pipe_skid_stage with a FIFO scoreboard.
module tb_pipe_skid_stage;
    import pipe_pkg::*;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned DATA_W  = 112;
    localparam int unsigned CTRL_W  = 12;
    localparam logic [CTRL_W-1:0] MASK = IDEX_KILL_MASK;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [DATA_W-1:0]  data;
        logic [CTRL_W-1:0]  ctrl;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    pipe_skid_stage_if #(.INSTR_W(INSTR_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

    pipe_skid_stage #(
        .INSTR_W   (INSTR_W),
        .DATA_W    (DATA_W),
        .CTRL_W    (CTRL_W),
        .NOP_INSTR (NOP_INSTR),
        .KILL_MASK (MASK)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    item_t             sb[$];
    logic              last_ok;
    logic [CTRL_W-1:0] last_ctrl;
    int unsigned       checks = 0;
    int unsigned       passes = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Compare every output against the scoreboard model.
    task automatic check_outputs();
        if (sb.size() != 0) begin
            chk("out_valid", 128'(bus.out_valid), 128'(1'b1));
            chk("out_instr", 128'(bus.out_instr), 128'(sb[0].instr));
            chk("out_data",  128'(bus.out_data),  128'(sb[0].data));
            chk("out_ctrl",  128'(bus.out_ctrl),  128'(sb[0].ctrl));
        end else begin
            chk("bubble_valid", 128'(bus.out_valid), 128'(1'b0));
            chk("bubble_instr", 128'(bus.out_instr), 128'(NOP_INSTR));
            chk("bubble_ctrl",  128'(bus.out_ctrl),
                128'(last_ok ? (last_ctrl & ~MASK) : {CTRL_W{1'b0}}));
        end
        chk("in_ready",  128'(bus.in_ready),  128'(sb.size() < 2));
        chk("occupancy", 128'(bus.occupancy), 128'(sb.size()));
    endtask

    // Check the current cycle, clock it, and advance the model.
    task automatic step();
        bit    p, o;
        item_t it;
        check_outputs();
        p  = bus.in_valid && (sb.size() < 2);
        o  = (sb.size() != 0) && bus.out_ready;
        it = '{instr: bus.in_instr, data: bus.in_data, ctrl: bus.in_ctrl};
        @(posedge clk);
        if (!rst) begin
            sb.delete();
            last_ok = 1'b0;
        end else if (flush) begin
            sb.delete();
        end else begin
            if (o) void'(sb.pop_front());
            if (p) sb.push_back(it);
        end
        if (sb.size() != 0) begin
            last_ok   = 1'b1;
            last_ctrl = sb[0].ctrl;
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [INSTR_W-1:0] ins,
                         input logic [CTRL_W-1:0] c, input logic rdy);
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.in_valid  = v;
        bus.in_instr  = ins;
        bus.in_data   = r[DATA_W-1:0];
        bus.in_ctrl   = c;
        bus.out_ready = rdy;
    endtask

    initial begin
        last_ok   = 1'b0;
        last_ctrl = '0;
        rst   = 1'b0;
        flush = 1'b0;
        drive(1'b0, 16'h0, 12'h0, 1'b1);
        @(posedge clk);
        #1;

        // Reset, then stream two entries.
        step();
        chk("rst_instr", 128'(bus.out_instr), 128'(16'h0800));
        chk("rst_ctrl",  128'(bus.out_ctrl),  128'(12'h000));
        rst = 1'b1;
        drive(1'b1, 16'h4123, 12'h111, 1'b1); step();
        chk("first_out", 128'(bus.out_instr), 128'(16'h4123));
        drive(1'b1, 16'h4124, 12'h222, 1'b1); step();
        chk("second_out", 128'(bus.out_instr), 128'(16'h4124));
        chk("second_occ", 128'(bus.occupancy), 128'(2'd1));
        drive(1'b0, 16'h0, 12'h0, 1'b1); step();
        step();

        // Stall and skid: the third offer is refused while FULL.
        drive(1'b1, 16'hA001, 12'h301, 1'b0); step();
        drive(1'b1, 16'hA002, 12'h302, 1'b0); step();
        chk("skid_occ",   128'(bus.occupancy), 128'(2'd2));
        chk("skid_ready", 128'(bus.in_ready),  128'(1'b0));
        drive(1'b1, 16'hA003, 12'h303, 1'b0); step();
        drive(1'b0, 16'h0, 12'h0, 1'b1); step();
        chk("drain_ready", 128'(bus.in_ready),  128'(1'b1));
        chk("drain_instr", 128'(bus.out_instr), 128'(16'hA002));
        step(); step();

        // Kill mask on a bubble after a held all-ones control vector.
        drive(1'b1, 16'hC001, 12'hFFF, 1'b1); step();
        drive(1'b0, 16'h0, 12'h0, 1'b1); step();
        chk("kill_ctrl", 128'(bus.out_ctrl), 128'(12'hF0F));
        step();

        // Flush in FULL with an entry offered.
        drive(1'b1, 16'hB001, 12'h401, 1'b0); step();
        drive(1'b1, 16'hB002, 12'h402, 1'b0); step();
        flush = 1'b1;
        drive(1'b1, 16'hB003, 12'h403, 1'b1); step();
        flush = 1'b0;
        chk("flush_occ",   128'(bus.occupancy), 128'(2'd0));
        chk("flush_instr", 128'(bus.out_instr), 128'(16'h0800));
        drive(1'b0, 16'h0, 12'h0, 1'b1); step(); step();

        // Reset and flush together with a push and pop in the same cycle.
        drive(1'b1, 16'hD001, 12'h501, 1'b1); step();
        rst   = 1'b0;
        flush = 1'b1;
        drive(1'b1, 16'hD002, 12'h502, 1'b1); step();
        chk("rf_valid", 128'(bus.out_valid), 128'(1'b0));
        chk("rf_ctrl",  128'(bus.out_ctrl),  128'(12'h000));
        rst   = 1'b1;
        flush = 1'b0;
        drive(1'b0, 16'h0, 12'h0, 1'b1); step(); step(); step();

        // Back-to-back push/pop with random instructions.
        drive(1'b1, 16'(($urandom())), 12'(($urandom())), 1'b1); step();
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 16'(($urandom())), 12'(($urandom())), 1'b1);
            step();
            chk("b2b_occ", 128'(bus.occupancy), 128'(2'd1));
        end
        drive(1'b0, 16'h0, 12'h0, 1'b1); step(); step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
